// File: rtl/pipeline_receive_fifo_pkg.sv
// pipeline_fifo_pkg: pointer width, occupancy helper and legal read latencies for pipeline_receive_fifo
package pipeline_fifo_pkg;
  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction
  function automatic int occupancy(input int wp, input int rp, input int pw);
    return (wp - rp) & ((1 << pw) - 1);
  endfunction
endpackage

// File: rtl/pipeline_receive_fifo_ram.sv
// fifo_dual_port_ram: simple dual-port RAM, one write port, one registered read port (MLAB up to 32 deep, else M20K)
module fifo_dual_port_ram #(
  parameter int WIDTH = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] rd_raw;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  if (AW <= 5) begin : g_mlab
    (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [2**AW];
    always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
    assign rd_raw = mem[raddr];
  end else begin : g_m20k
    (* ramstyle = "M20K" *) logic [WIDTH-1:0] mem [2**AW];
    always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
    assign rd_raw = mem[raddr];
  end
  always_comb rdata_d = re ? rd_raw : rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/pipeline_receive_fifo.sv
// pipeline_receive_fifo: hyperpipe sink FIFO with early almostFull; PIPE_RX_OVERFLOW_DETECT_EN adds sticky overflowError
module pipeline_receive_fifo
  import pipeline_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int ALMOST_FULL_MARGIN = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPE_RX_OVERFLOW_DETECT_EN
  output logic             overflowError,
`endif
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] dataIn,
  output logic             almostFull,
  input  logic             readRequest,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataOutValid,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW = ptr_width(DEPTH_LOG2);
  if (ALMOST_FULL_MARGIN >= DEPTH) begin : g_err_margin
    $error("ALMOST_FULL_MARGIN must be below DEPTH");
  end
  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_err_rl
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DEPTH_LOG2 < 2) begin : g_err_depth
    $error("DEPTH_LOG2 must be at least 2");
  end
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic almost_full_q, almost_full_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic full, wr_ok, rd_ok;
  logic [WIDTH-1:0] ram_q;
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[PW-2:0] == rp_q[PW-2:0]);
    wr_ok = writeEnable && !full;
    rd_ok = readRequest && !empty;
    wp_d = wp_q + PW'(wr_ok);
    rp_d = rp_q + PW'(rd_ok);
    almost_full_d = occupancy(int'(wp_d), int'(rp_d), PW) >= DEPTH - ALMOST_FULL_MARGIN;
    vld_d = (vld_q << 1) | READ_LATENCY'(rd_ok);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      almost_full_q <= 1'b1;
      vld_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      almost_full_q <= almost_full_d;
      vld_q <= vld_d;
    end
  fifo_dual_port_ram #(.WIDTH(WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_ok),
    .waddr(wp_q[PW-2:0]),
    .wdata(dataIn),
    .re(rd_ok),
    .raddr(rp_q[PW-2:0]),
    .rdata(ram_q)
  );
  if (READ_LATENCY == 1) begin : g_l1
    assign dataOut = ram_q;
  end else begin : g_l2
    logic [WIDTH-1:0] dout_q, dout_d;
    always_comb dout_d = vld_q[0] ? ram_q : dout_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dout_q <= '0;
      else dout_q <= dout_d;
    assign dataOut = dout_q;
  end
  assign almostFull = almost_full_q;
  assign dataOutValid = vld_q[READ_LATENCY-1];
`ifdef PIPE_RX_OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = ovf_q || (writeEnable && full);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  assign overflowError = ovf_q;
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(writeEnable && full))
    else $error("write while full");
`endif
`endif
endmodule

// File: tb/tb_pipeline_receive_fifo.sv
// tb_pipeline_receive_fifo: randomized queue-model check of pipeline_receive_fifo at read latency 1 and 2
module tb_pipeline_receive_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic we = 1'b0;
  logic re = 1'b0;
  logic [31:0] din = '0;
  logic af1, e1, v1, af2, e2, v2;
  logic [31:0] d1, d2;
`ifdef PIPE_RX_OVERFLOW_DETECT_EN
  logic ov1, ov2;
`endif
  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic pv = 1'b0;
  logic [31:0] pd = '0;
  logic ovf_m = 1'b0;
  always #5 clk = ~clk;
  pipeline_receive_fifo #(.WIDTH(32), .DEPTH_LOG2(4), .ALMOST_FULL_MARGIN(6), .READ_LATENCY(1)) u1 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PIPE_RX_OVERFLOW_DETECT_EN
    .overflowError(ov1),
`endif
    .writeEnable(we),
    .dataIn(din),
    .almostFull(af1),
    .readRequest(re),
    .dataOut(d1),
    .dataOutValid(v1),
    .empty(e1)
  );
  pipeline_receive_fifo #(.WIDTH(32), .DEPTH_LOG2(4), .ALMOST_FULL_MARGIN(6), .READ_LATENCY(2)) u2 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PIPE_RX_OVERFLOW_DETECT_EN
    .overflowError(ov2),
`endif
    .writeEnable(we),
    .dataIn(din),
    .almostFull(af2),
    .readRequest(re),
    .dataOut(d2),
    .dataOutValid(v2),
    .empty(e2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    logic wok, rok;
    logic [31:0] rd;
    rd = '0;
    we = w;
    din = d;
    re = r;
    wok = w && q.size() < 16;
    rok = r && q.size() != 0;
    if (w && q.size() == 16) ovf_m = 1'b1;
    if (rok) rd = q.pop_front();
    if (wok) q.push_back(d);
    @(posedge clk);
    #1;
    chk("valid_l1", v1, rok);
    if (rok) chk("data_l1", d1, rd);
    chk("valid_l2", v2, pv);
    if (pv) chk("data_l2", d2, pd);
    pv = rok;
    pd = rd;
    chk("afull_l1", af1, q.size() >= 10);
    chk("afull_l2", af2, q.size() >= 10);
    chk("empty_l1", e1, q.size() == 0);
    chk("empty_l2", e2, q.size() == 0);
`ifdef PIPE_RX_OVERFLOW_DETECT_EN
    chk("ovf_l1", ov1, ovf_m);
    chk("ovf_l2", ov2, ovf_m);
`endif
    we = 1'b0;
    re = 1'b0;
  endtask
  task automatic do_reset();
    we = 1'b0;
    re = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_afull_l1", af1, 1);
    chk("rst_afull_l2", af2, 1);
    chk("rst_empty_l1", e1, 1);
    chk("rst_empty_l2", e2, 1);
    chk("rst_valid_l1", v1, 0);
    chk("rst_valid_l2", v2, 0);
    chk("rst_dout_l1", d1, 0);
    chk("rst_dout_l2", d2, 0);
    q.delete();
    pv = 1'b0;
    pd = '0;
    ovf_m = 1'b0;
    @(negedge clk);
    chk("rst_hold_afull", af1, 1);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
  endtask
  task automatic drain();
    while (q.size() != 0) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
  endtask
  initial begin
    #2;
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 70; i++) cycle(1'b1, $urandom, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b1);
    cycle(1'b0, '0, 1'b0);
    drain();
    cycle(1'b1, 32'hA5, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (i < 200) cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0);
      else cycle(($urandom % 3) == 0, $urandom, ($urandom % 4) != 0);
    end
    drain();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
